// File: rtl/jackpot_pkg.sv
// -----------------------------------------------------------------------------
// jackpot_pkg
// Shared definitions for the jackpot arcade game:
//   state_e            FSM state encoding (IDLE / RUN / FLASH)
//   TICK_DIV0_DEFAULT  walk-step period at level 0 for the 125 MHz board clock
//   SYNC_STAGES        depth of the switch synchroniser (must be >= 2)
// -----------------------------------------------------------------------------
package jackpot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLASH = 2'd2
   } state_e;

   localparam int TICK_DIV0_DEFAULT = 62_500_000;
   localparam int SYNC_STAGES       = 2;

endpackage

// File: rtl/jackpot_tick_gen.sv
// -----------------------------------------------------------------------------
// jackpot_tick_gen
// Programmable divider: counts 0..period-1 and pulses tick on the terminal
// count.
// Ports:
//   CLOCK    in   clock
//   RESET_N  in   asynchronous active-low reset (counter -> 0)
//   clr      in   synchronous clear, restarts a full period
//   period   in   divide ratio (callers guarantee >= 2)
//   tick     out  high during the last cycle of each period
// The period is read live. The only client changes it together with a state
// change, which also asserts clr, so this behaves the same as sampling the
// period when the counter wraps.
// -----------------------------------------------------------------------------
module jackpot_tick_gen #(
   parameter int PW = 26
) (
   input  logic          CLOCK,
   input  logic          RESET_N,
   input  logic          clr,
   input  logic [PW-1:0] period,
   output logic          tick
);

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;
   logic          last_s;

   // Terminal-count detect and next counter value.
   // Using >= lets the counter recover at once if the period ever shrinks
   // below the current count.
   always_comb begin
      last_s = (cnt_q >= (period - PW'(1)));
      cnt_d  = cnt_q;
      if (clr || last_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = last_s;

endmodule

// File: rtl/jackpot_arcade.sv
// -----------------------------------------------------------------------------
// jackpot_arcade
// A single lit LED walks across N_LEDS outputs, getting faster as the level
// rises.
//   - Flipping the switch under the lit LED up is a hit. A hit flashes the
//     LEDs, raises the level and adds to a saturating score.
//   - Flipping any other switch up (or several at once) is a miss. A miss drops
//     back to idle and resets the level to 0.
// Ports:
//   CLOCK     in   sole clock
//   RESET_N   in   asynchronous active-low reset
//   SWITCHES  in   raw slide switches, asynchronous to CLOCK
//   LEDS      out  LED drive (registered)
//   LEVEL     out  current speed level (registered)
//   SCORE     out  saturating hit count (registered)
//   HIT       out  one-cycle pulse on a hit (registered)
//   MISS      out  one-cycle pulse on a miss (registered)
// -----------------------------------------------------------------------------
module jackpot_arcade
   import jackpot_pkg::*;
#(
   parameter int N_LEDS      = 4,
   parameter int TICK_DIV0   = TICK_DIV0_DEFAULT,
   parameter int N_LEVELS    = 4,
   parameter int FLASH_STEPS = 6,
   parameter int SCORE_W     = 8
) (
   input  logic                        CLOCK,
   input  logic                        RESET_N,
   input  logic [N_LEDS-1:0]           SWITCHES,
   output logic [N_LEDS-1:0]           LEDS,
   output logic [$clog2(N_LEVELS)-1:0] LEVEL,
   output logic [SCORE_W-1:0]          SCORE,
   output logic                        HIT,
   output logic                        MISS
);

   localparam int LW = $clog2(N_LEVELS);
   localparam int PW = $clog2(TICK_DIV0 + 1);
   localparam int FW = $clog2(FLASH_STEPS + 1);

   localparam logic [N_LEDS-1:0]  LED_MSB   = {1'b1, {(N_LEDS-1){1'b0}}};
   localparam logic [N_LEDS-1:0]  LED_ALL   = {N_LEDS{1'b1}};
   localparam logic [LW-1:0]      LEVEL_MAX = LW'(N_LEVELS - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   // Input path: stage 0 is the newest sample.
   logic [SYNC_STAGES-1:0][N_LEDS-1:0] sync_q;
   logic [SYNC_STAGES-1:0][N_LEDS-1:0] sync_d;
   logic [N_LEDS-1:0]                  prev_q;
   logic [N_LEDS-1:0]                  prev_d;
   logic [N_LEDS-1:0]                  rise_s;
   logic                               rise_any_s;
   logic                               rise_one_s;

   // Game state.
   state_e            state_q;
   state_e            state_d;
   logic [N_LEDS-1:0] leds_q;
   logic [N_LEDS-1:0] leds_d;
   logic [LW-1:0]     level_q;
   logic [LW-1:0]     level_d;
   logic [SCORE_W-1:0] score_q;
   logic [SCORE_W-1:0] score_d;
   logic              hit_q;
   logic              hit_d;
   logic              miss_q;
   logic              miss_d;
   logic [FW-1:0]     fcnt_q;
   logic [FW-1:0]     fcnt_d;

   // Tick interface.
   logic [PW-1:0] shifted_s;
   logic [PW-1:0] period_s;
   logic          tick_s;
   logic          clr_s;

   // Synchroniser shift, previous-value capture and rising-edge detect.
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], SWITCHES};
      prev_d     = sync_q[SYNC_STAGES-1];
      rise_s     = sync_q[SYNC_STAGES-1] & ~prev_q;
      rise_any_s = (rise_s != '0);
      // Exactly one bit set: nonzero, and clearing the lowest set bit leaves 0.
      rise_one_s = rise_any_s && ((rise_s & (rise_s - N_LEDS'(1))) == '0);
   end

   // Walk period for the current level. Deep levels are clamped to 2 cycles.
   always_comb begin
      shifted_s = PW'(TICK_DIV0) >> level_q;
      if (shifted_s < PW'(2)) begin
         period_s = PW'(2);
      end else begin
         period_s = shifted_s;
      end
   end

   // Game FSM: next state plus next values of every registered output.
   always_comb begin
      state_d = state_q;
      leds_d  = leds_q;
      level_d = level_q;
      score_d = score_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_IDLE: begin
            leds_d = '0;
            fcnt_d = '0;
            // The starting edge only starts the game; it is not judged.
            if (rise_any_s) begin
               state_d = ST_RUN;
               leds_d  = LED_MSB;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Judging uses the LEDS already on display. A simultaneous tick
            // shift is dropped because the state change restarts the walk.
            if (rise_any_s) begin
               if (rise_one_s && (rise_s == leds_q)) begin
                  hit_d   = 1'b1;
                  state_d = ST_FLASH;
                  leds_d  = LED_ALL;
                  fcnt_d  = '0;
                  if (score_q != SCORE_MAX) begin
                     score_d = score_q + SCORE_W'(1);
                  end else begin
                     score_d = score_q;
                  end
                  if (level_q != LEVEL_MAX) begin
                     level_d = level_q + LW'(1);
                  end else begin
                     level_d = level_q;
                  end
               end else begin
                  miss_d  = 1'b1;
                  state_d = ST_IDLE;
                  leds_d  = '0;
                  level_d = '0;
               end
            end else if (tick_s) begin
               if (leds_q[0]) begin
                  leds_d = LED_MSB;
               end else begin
                  leds_d = leds_q >> 1;
               end
            end else begin
               leds_d = leds_q;
            end
         end
         ST_FLASH: begin
            // Rises are deliberately ignored while flashing.
            if (tick_s) begin
               if (fcnt_q == FW'(FLASH_STEPS - 1)) begin
                  state_d = ST_RUN;
                  leds_d  = LED_MSB;
                  fcnt_d  = '0;
               end else begin
                  leds_d = ~leds_q;
                  fcnt_d = fcnt_q + FW'(1);
               end
            end else begin
               leds_d = leds_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            leds_d  = '0;
            level_d = '0;
            fcnt_d  = '0;
         end
      endcase
   end

   // Any state change restarts the divider so the first step is a full period.
   assign clr_s = (state_d != state_q);

   jackpot_tick_gen #(
      .PW(PW)
   ) u_tick (
      .CLOCK  (CLOCK),
      .RESET_N(RESET_N),
      .clr    (clr_s),
      .period (period_s),
      .tick   (tick_s)
   );

   // All state and output registers; reset forces every one to zero / IDLE.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync_q  <= '0;
         prev_q  <= '0;
         state_q <= ST_IDLE;
         leds_q  <= '0;
         level_q <= '0;
         score_q <= '0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         state_q <= state_d;
         leds_q  <= leds_d;
         level_q <= level_d;
         score_q <= score_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign LEDS  = leds_q;
   assign LEVEL = level_q;
   assign SCORE = score_q;
   assign HIT   = hit_q;
   assign MISS  = miss_q;

endmodule

// File: tb/tb_jackpot_arcade.sv
// -----------------------------------------------------------------------------
// tb_jackpot_arcade
// Scoreboard bench for jackpot_arcade.
// The reference model describes the game as a list of timed segments, and
// derives the expected LEDS for any clock edge arithmetically:
//   - which segment is active (IDLE, RUN or FLASH);
//   - the edge at which that segment started;
//   - the level and score that hold during it.
// Stimulus pushes expected HIT/MISS events into a queue. A negedge monitor
// compares the DUT state every cycle and pops one event per pulse.
// -----------------------------------------------------------------------------
module tb_jackpot_arcade;

   localparam int N   = 4;
   localparam int TD  = 16;
   localparam int NL  = 4;
   localparam int FS  = 6;
   localparam int SW  = 2;
   localparam int SCORE_MAX = 3;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FLASH = 2;

   logic          CLOCK    = 1'b0;
   logic          RESET_N  = 1'b1;
   logic [N-1:0]  SWITCHES = 4'b0000;
   logic [N-1:0]  LEDS;
   logic [1:0]    LEVEL;
   logic [SW-1:0] SCORE;
   logic          HIT;
   logic          MISS;

   jackpot_arcade #(
      .N_LEDS     (N),
      .TICK_DIV0  (TD),
      .N_LEVELS   (NL),
      .FLASH_STEPS(FS),
      .SCORE_W    (SW)
   ) dut (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .SWITCHES(SWITCHES),
      .LEDS    (LEDS),
      .LEVEL   (LEVEL),
      .SCORE   (SCORE),
      .HIT     (HIT),
      .MISS    (MISS)
   );

   always #5 CLOCK = ~CLOCK;

   int cyc = 0;
   always @(posedge CLOCK) cyc <= cyc + 1;

   typedef struct {
      int mode;
      int entry;
      int level;
      int score;
   } seg_t;

   typedef struct {
      bit is_hit;
      int score;
      int level;
      int at;
   } ev_t;

   seg_t cur;
   seg_t prev;
   ev_t  exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic int per(input int l);
      int p;
      p = TD >> l;
      return (p < 2) ? 2 : p;
   endfunction

   function automatic seg_t seg_at(input int n);
      return (n >= cur.entry) ? cur : prev;
   endfunction

   function automatic int mode_at(input int n);
      seg_t s;
      s = seg_at(n);
      if (s.mode == M_FLASH && ((n - s.entry) / per(s.level)) >= FS) return M_RUN;
      return s.mode;
   endfunction

   function automatic logic [N-1:0] leds_at(input int n);
      seg_t s;
      int p;
      int j;
      logic [N-1:0] msb;
      s   = seg_at(n);
      p   = per(s.level);
      j   = n - s.entry;
      msb = 4'b1000;
      if (s.mode == M_RUN) return msb >> ((j / p) % N);
      if (s.mode == M_FLASH) begin
         if ((j / p) < FS) return (((j / p) % 2) == 0) ? 4'b1111 : 4'b0000;
         return msb >> (((j - FS * p) / p) % N);
      end
      return 4'b0000;
   endfunction

   task automatic model_reset();
      cur.mode  = M_IDLE;
      cur.entry = 0;
      cur.level = 0;
      cur.score = 0;
      prev      = cur;
      exp_q.delete();
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLOCK);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Drive new switch values at posedge+1 (edge number e = cyc).
   // Any rise is judged in the cycle after edge e+2, and its effect lands at edge e+3.
   task automatic set_sw(input logic [N-1:0] v);
      logic [N-1:0] r;
      logic [N-1:0] l;
      int e;
      int m;
      seg_t s;
      r = v & ~SWITCHES;
      SWITCHES = v;
      e = cyc;
      if (r != 4'b0000) begin
         m = mode_at(e + 2);
         l = leds_at(e + 2);
         s = cur;
         s.entry = e + 3;
         if (m == M_IDLE) begin
            s.mode = M_RUN;
            prev = cur;
            cur = s;
         end else if (m == M_RUN) begin
            if (r == l) begin
               s.score = (s.score < SCORE_MAX) ? s.score + 1 : SCORE_MAX;
               s.level = (s.level < NL - 1) ? s.level + 1 : NL - 1;
               s.mode  = M_FLASH;
               exp_q.push_back('{1'b1, s.score, s.level, e + 3});
            end else begin
               s.level = 0;
               s.mode  = M_IDLE;
               exp_q.push_back('{1'b0, s.score, 0, e + 3});
            end
            prev = cur;
            cur = s;
         end
      end
   endtask

   // One-cycle switch flick, then idle long enough for the effect to settle.
   task automatic pulse_sw(input logic [N-1:0] mask);
      set_sw(mask);
      step(1);
      set_sw(4'b0000);
      step(3);
   endtask

   // Wait (per the model) until the judged LEDS equal target, then flick mask.
   task automatic raise_when(input logic [N-1:0] target, input logic [N-1:0] mask);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (mode_at(cyc + 2) == M_RUN && leds_at(cyc + 2) == target) begin
            found = 1'b1;
            break;
         end
         step(1);
      end
      if (found) begin
         pulse_sw(mask);
      end else begin
         n_cmp++;
         n_fail++;
         $display("FAIL raise_when: target %b never reached", target);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_leds"},  int'(LEDS),  0);
      chk({tag, "_level"}, int'(LEVEL), 0);
      chk({tag, "_score"}, int'(SCORE), 0);
      chk({tag, "_hit"},   int'(HIT),   0);
      chk({tag, "_miss"},  int'(MISS),  0);
   endtask

   // Monitor: per-cycle state comparison and scoreboard pop on each pulse.
   always @(negedge CLOCK) begin
      seg_t s;
      logic [N-1:0] el;
      ev_t ev;
      el = leds_at(cyc);
      s  = seg_at(cyc);
      n_cmp++;
      if (LEDS !== el || int'(LEVEL) != s.level || int'(SCORE) != s.score) begin
         n_fail++;
         $display("FAIL state @%0d: LEDS=%b LEVEL=%0d SCORE=%0d, expected LEDS=%b LEVEL=%0d SCORE=%0d",
                  cyc, LEDS, LEVEL, SCORE, el, s.level, s.score);
      end
      if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL missing_pulse @%0d: no pulse seen, expected %s at %0d",
                  cyc, exp_q[0].is_hit ? "HIT" : "MISS", exp_q[0].at);
         void'(exp_q.pop_front());
      end
      if (HIT || MISS) begin
         n_cmp++;
         if (HIT && MISS) begin
            n_fail++;
            $display("FAIL pulse @%0d: HIT=1 MISS=1, expected only one", cyc);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pulse @%0d: HIT=%0d MISS=%0d, expected none", cyc, HIT, MISS);
         end else begin
            ev = exp_q.pop_front();
            if (HIT != ev.is_hit || cyc != ev.at || int'(SCORE) != ev.score || int'(LEVEL) != ev.level) begin
               n_fail++;
               $display("FAIL event @%0d: HIT=%0d SCORE=%0d LEVEL=%0d, expected HIT=%0d at %0d SCORE=%0d LEVEL=%0d",
                        cyc, HIT, SCORE, LEVEL, ev.is_hit, ev.at, ev.score, ev.level);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] tgt;
      model_reset();
      #2;
      RESET_N = 1'b0;
      #1;
      chk_all_zero("reset");
      step(3);
      #2;
      RESET_N = 1'b1;
      step(2);

      // Start the walk and follow it through a full wrap.
      pulse_sw(4'b0001);
      step(70);

      // Hit on 0010: flash at period 8, then walk at period 8.
      raise_when(4'b0010, 4'b0010);
      step(90);

      // Wrong switch: miss, level back to 0, score held.
      raise_when(4'b0100, 4'b1000);
      step(6);

      // Two simultaneous rises covering the lit LED are still a miss.
      pulse_sw(4'b0001);
      raise_when(4'b0100, 4'b0110);
      step(6);

      // Five hits in a row: level and 2-bit score both saturate at 3.
      pulse_sw(4'b0001);
      for (int i = 0; i < 5; i++) begin
         tgt = 4'b0001 << $urandom_range(0, N - 1);
         raise_when(tgt, tgt);
      end
      step(2);
      chk("sat_level", int'(LEVEL), 3);
      chk("sat_score", int'(SCORE), 3);

      // Asynchronous reset in the middle of FLASH.
      raise_when(4'b1000, 4'b1000);
      step(2);
      @(negedge CLOCK);
      #2;
      RESET_N = 1'b0;
      model_reset();
      #1;
      chk_all_zero("flash_reset");
      step(3);
      #2;
      RESET_N = 1'b1;
      step(2);
      pulse_sw(4'b0001);
      step(40);

      // Randomized play: a mix of aimed hits and random flicks.
      for (int i = 0; i < 60; i++) begin
         step($urandom_range(0, 12));
         if (($urandom % 2) == 0 && mode_at(cyc + 2) == M_RUN) begin
            pulse_sw(leds_at(cyc + 2));
         end else begin
            pulse_sw(4'($urandom_range(1, 15)));
         end
      end

      step(120);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
